// File: rtl/score_bcd8.sv
// Sequential shift-add-3 binary-to-BCD converter driving eight display digit registers.
// Define SCORE_SAT_EN to show 99999999 on overflow instead of the value mod 10^8.
module score_bcd8 #(
    parameter int BIN_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bin_valid,
    input  logic [BIN_W-1:0] bin_data,
    output logic             bin_ready,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd4,
    output logic [3:0]       bcd5,
    output logic [3:0]       bcd6,
    output logic [3:0]       bcd7,
    output logic [3:0]       bcd8
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t           state;
    logic [BIN_W-1:0] shift_reg;
    logic [35:0]      acc;
    logic [35:0]      acc_adj;
    logic [35:0]      acc_next;
    logic [CNT_W-1:0] cnt;
    logic             lost;
    logic             ovf_next;
    logic [31:0]      load_digits;

    // Add-3 correction on every digit, then shift the next binary bit in from the MSB end
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 9; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        acc_next = {acc_adj[34:0], shift_reg[BIN_W-1]};
    end

    // A bit falling off the accumulator top can only mean overflow, so it is folded into ovf
    always_comb begin
        ovf_next = lost | acc_adj[35] | (acc_next[35:32] != 4'd0);
`ifdef SCORE_SAT_EN
        load_digits = ovf_next ? {8{4'd9}} : acc_next[31:0];
`else
        load_digits = acc_next[31:0];
`endif
    end

    // Digits are written on the final shift edge so they appear together with done in LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            acc       <= '0;
            cnt       <= '0;
            lost      <= 1'b0;
            bin_ready <= 1'b1;
            done      <= 1'b0;
            ovf       <= 1'b0;
            bcd1      <= 4'd0;
            bcd2      <= 4'd0;
            bcd3      <= 4'd0;
            bcd4      <= 4'd0;
            bcd5      <= 4'd0;
            bcd6      <= 4'd0;
            bcd7      <= 4'd0;
            bcd8      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bin_valid) begin
                        shift_reg <= bin_data;
                        acc       <= '0;
                        lost      <= 1'b0;
                        cnt       <= CNT_W'(BIN_W);
                        bin_ready <= 1'b0;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    acc       <= acc_next;
                    shift_reg <= shift_reg << 1;
                    lost      <= lost | acc_adj[35];
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= LOAD;
                        done  <= 1'b1;
                        ovf   <= ovf_next;
                        bcd1  <= load_digits[3:0];
                        bcd2  <= load_digits[7:4];
                        bcd3  <= load_digits[11:8];
                        bcd4  <= load_digits[15:12];
                        bcd5  <= load_digits[19:16];
                        bcd6  <= load_digits[23:20];
                        bcd7  <= load_digits[27:24];
                        bcd8  <= load_digits[31:28];
                    end
                end
                LOAD: begin
                    done      <= 1'b0;
                    bin_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd8.sv
// Self-checking bench for score_bcd8: directed cases plus a random sweep against a decimal model.
// Follows SCORE_SAT_EN the same way as the design so either build can be checked.
module tb_score_bcd8;

    logic        clk;
    logic        rst;
    logic        bin_valid;
    logic [26:0] bin_data;
    logic        bin_ready;
    logic        done;
    logic        ovf;
    logic [3:0]  bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7, bcd8;

    int          total;
    int          bad;
    logic [32:0] lastExp;

    score_bcd8 #(.BIN_W(27)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_valid (bin_valid),
        .bin_data  (bin_data),
        .bin_ready (bin_ready),
        .done      (done),
        .ovf       (ovf),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .bcd3      (bcd3),
        .bcd4      (bcd4),
        .bcd5      (bcd5),
        .bcd6      (bcd6),
        .bcd7      (bcd7),
        .bcd8      (bcd8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] observed();
        return {ovf, bcd8, bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1};
    endfunction

    // Expected {ovf, eight display digits} from plain decimal arithmetic
    function automatic logic [32:0] modelOut(input longint v);
        longint      m;
        logic [31:0] d;
        d = '0;
`ifdef SCORE_SAT_EN
        if (v > 64'd99999999) return {1'b1, {8{4'd9}}};
`endif
        m = v % 100000000;
        for (int i = 0; i < 8; i++) begin
            d[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {(v > 64'd99999999), d};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic startConv(input logic [26:0] value);
        int w;
        w = 0;
        while (bin_ready !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        checkOutput("ready_wait", 64'(bin_ready), 64'd1);
        bin_valid = 1'b1;
        bin_data  = value;
        @(negedge clk);
        bin_valid = 1'b0;
        checkOutput("accept_ready_low", 64'(bin_ready), 64'd0);
    endtask

    // Displayed value must hold at lastExp until the done cycle, then match the model
    task automatic waitDone(input int expCycles, input logic [26:0] value);
        int          cycles;
        int          holdErr;
        logic [32:0] exp;
        cycles  = 0;
        holdErr = 0;
        exp     = modelOut(longint'(value));
        do begin
            @(negedge clk);
            cycles++;
            if (done !== 1'b1 && observed() !== lastExp) holdErr++;
        end while (done !== 1'b1 && cycles < expCycles + 30);
        checkOutput("latency", 64'(cycles), 64'(expCycles));
        checkOutput("done_high", 64'(done), 64'd1);
        checkOutput("result", 64'(observed()), 64'(exp));
        checkOutput("hold", 64'(holdErr), 64'd0);
        lastExp = exp;
        @(negedge clk);
        checkOutput("done_pulse", 64'(done), 64'd0);
        checkOutput("ready_back", 64'(bin_ready), 64'd1);
    endtask

    task automatic applyStimulus(input logic [26:0] value);
        startConv(value);
        waitDone(27, value);
    endtask

    initial begin
        int pulses;
        total     = 0;
        bad       = 0;
        lastExp   = '0;
        rst       = 1'b1;
        bin_valid = 1'b0;
        bin_data  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 64'(bin_ready), 64'd1);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_outputs", 64'(observed()), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single conversion 12345678");
        applyStimulus(27'd12345678);
        checkOutput("digits_12345678", 64'({bcd8, bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1}), 64'h12345678);

        $display("[TB] overflow value 100000123");
        applyStimulus(27'd100000123);
        checkOutput("ovf_set", 64'(ovf), 64'd1);

        $display("[TB] back-to-back 99999999 then 0 with valid held");
        bin_valid = 1'b1;
        bin_data  = 27'd99999999;
        @(negedge clk);
        bin_data = 27'd0;
        checkOutput("b2b_first_accept", 64'(bin_ready), 64'd0);
        waitDone(27, 27'd99999999);
        @(negedge clk);
        bin_valid = 1'b0;
        checkOutput("b2b_second_accept", 64'(bin_ready), 64'd0);
        waitDone(27, 27'd0);

        $display("[TB] valid pulsed during conversion is ignored");
        startConv(27'd4321);
        @(negedge clk);
        bin_valid = 1'b1;
        bin_data  = 27'd777;
        @(negedge clk);
        bin_valid = 1'b0;
        waitDone(25, 27'd4321);

        $display("[TB] reset in the middle of a conversion");
        startConv(27'd55555);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_ready", 64'(bin_ready), 64'd1);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_outputs", 64'(observed()), 64'd0);
        lastExp = '0;
        pulses  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checkOutput("midrst_discarded", 64'(pulses), 64'd0);

        $display("[TB] boundary values and random sweep");
        applyStimulus(27'd99999999);
        applyStimulus(27'd100000000);
        applyStimulus(27'h7FFFFFF);
        applyStimulus(27'd1);
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(27'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
